// File: rtl/collision_scheduler_pkg.sv
// Shared constants and types for the per-frame collision scheduler.
// Object counts and sizes, the fixed player row, the packed position type
// and the scheduler FSM encoding live here so every file agrees on them.
package collision_scheduler_pkg;

    localparam int MAX_ENEMY         = 3;
    localparam int MAX_ENEMY_BULLET  = 3;
    localparam int MAX_PLAYER_BULLET = 3;

    localparam int ENEMY_WIDTH   = 36;
    localparam int ENEMY_HEIGHT  = 24;
    localparam int PLAYER_WIDTH  = 24;
    localparam int PLAYER_HEIGHT = 36;
    localparam int BULLET_WIDTH  = 4;
    localparam int BULLET_HEIGHT = 16;
    localparam int PLAYER_Y      = 372;

    localparam int POS_W = 19;

    // Packed screen position, x in the upper bits to match the port packing.
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } pos_t;

    // Off-screen parking spot for unused objects.
    localparam pos_t NONE_POS = '{x: 10'd720, y: 9'd500};

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SCAN_PB_E  = 3'd1,
        SCAN_PB_EB = 3'd2,
        SCAN_EB_P  = 3'd3,
        DONE       = 3'd4
    } state_t;

    // Narrow an integer size constant to the x (10-bit) or y (9-bit) field.
    function automatic logic [9:0] to_w(input int v);
        return v[9:0];
    endfunction

    function automatic logic [8:0] to_h(input int v);
        return v[8:0];
    endfunction

endpackage

// File: rtl/collision_rect_cmp.sv
// Strict axis-aligned rectangle overlap test. Right/bottom edges are summed
// one bit wider than the coordinates so nothing wraps; touching edges miss.
module collision_rect_cmp (
    input  logic [18:0] a_pos_i,
    input  logic [9:0]  a_w_i,
    input  logic [8:0]  a_h_i,
    input  logic [18:0] b_pos_i,
    input  logic [9:0]  b_w_i,
    input  logic [8:0]  b_h_i,
    output logic        hit_o
);
    logic [10:0] ax, bx, ax_end, bx_end;
    logic [9:0]  ay, by, ay_end, by_end;

    assign ax     = {1'b0, a_pos_i[18:9]};
    assign bx     = {1'b0, b_pos_i[18:9]};
    assign ay     = {1'b0, a_pos_i[8:0]};
    assign by     = {1'b0, b_pos_i[8:0]};
    assign ax_end = ax + {1'b0, a_w_i};
    assign bx_end = bx + {1'b0, b_w_i};
    assign ay_end = ay + {1'b0, a_h_i};
    assign by_end = by + {1'b0, b_h_i};

    assign hit_o = (ax < bx_end) && (bx < ax_end) && (ay < by_end) && (by < ay_end);

endmodule

// File: rtl/collision_scheduler.sv
// Time-multiplexed collision controller: on a frame tick it snapshots every
// object, then walks player-bullet/enemy, player-bullet/enemy-bullet and
// enemy-bullet/player pairs through one shared comparator, one pair a clock.
// Build option: define COLLISION_BULLET_CANCEL_EN to run the
// player-bullet/enemy-bullet phase (bullets cancel); otherwise it is skipped.
module collision_scheduler
    import collision_scheduler_pkg::*;
(
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic                           i_FrameStart,
    input  logic [MAX_ENEMY-1:0]           i_EnemyState,
    input  logic [MAX_ENEMY_BULLET-1:0]    i_EnemyBulletState,
    input  logic [MAX_PLAYER_BULLET-1:0]   i_PlayerBulletState,
    input  logic                           i_PlayerState,
    input  logic [19*MAX_ENEMY-1:0]        i_EnemyPosition,
    input  logic [19*MAX_ENEMY_BULLET-1:0] i_EnemyBulletPosition,
    input  logic [19*MAX_PLAYER_BULLET-1:0] i_PlayerBulletPosition,
    input  logic [9:0]                     i_PlayerPosition,
    output logic [MAX_ENEMY-1:0]           o_EnemyKill,
    output logic [MAX_ENEMY_BULLET-1:0]    o_EnemyBulletKill,
    output logic [MAX_PLAYER_BULLET-1:0]   o_PlayerBulletKill,
    output logic                           o_PlayerHit,
    output logic                           o_AllEnemiesDown,
    output logic                           o_Busy,
    output logic                           o_Done
);
    localparam int AW  = (MAX_PLAYER_BULLET > 1) ? $clog2(MAX_PLAYER_BULLET) : 1;
    localparam int EW  = (MAX_ENEMY > 1) ? $clog2(MAX_ENEMY) : 1;
    localparam int EBW = (MAX_ENEMY_BULLET > 1) ? $clog2(MAX_ENEMY_BULLET) : 1;
    localparam int BW  = (EW > EBW) ? EW : EBW;

    localparam logic [AW-1:0] A_LAST  = AW'(MAX_PLAYER_BULLET - 1);
    localparam logic [BW-1:0] E_LAST  = BW'(MAX_ENEMY - 1);
    localparam logic [BW-1:0] EB_LAST = BW'(MAX_ENEMY_BULLET - 1);

    localparam logic [9:0] BUL_W = to_w(BULLET_WIDTH);
    localparam logic [8:0] BUL_H = to_h(BULLET_HEIGHT);
    localparam logic [9:0] ENE_W = to_w(ENEMY_WIDTH);
    localparam logic [8:0] ENE_H = to_h(ENEMY_HEIGHT);
    localparam logic [9:0] PLY_W = to_w(PLAYER_WIDTH);
    localparam logic [8:0] PLY_H = to_h(PLAYER_HEIGHT);
    localparam logic [8:0] PLY_Y = to_h(PLAYER_Y);

    pos_t in_e  [MAX_ENEMY];
    pos_t in_eb [MAX_ENEMY_BULLET];
    pos_t in_pb [MAX_PLAYER_BULLET];

    state_t                         state_q;
    pos_t                           snap_e_q  [MAX_ENEMY];
    pos_t                           snap_eb_q [MAX_ENEMY_BULLET];
    pos_t                           snap_pb_q [MAX_PLAYER_BULLET];
    logic [9:0]                     snap_px_q;
    logic [MAX_ENEMY-1:0]           snap_es_q;
    logic [MAX_ENEMY_BULLET-1:0]    snap_ebs_q;
    logic [MAX_PLAYER_BULLET-1:0]   snap_pbs_q;
    logic                           snap_ps_q;
    logic [AW-1:0]                  a_q;
    logic [BW-1:0]                  b_q;
    logic [MAX_ENEMY-1:0]           ek_q;
    logic [MAX_ENEMY_BULLET-1:0]    ebk_q;
    logic [MAX_PLAYER_BULLET-1:0]   pbk_q;
    logic                           hit_q, alldown_q, busy_q, done_q;

    pos_t       cmp_a, cmp_b;
    logic [9:0] cmp_aw, cmp_bw;
    logic [8:0] cmp_ah, cmp_bh;
    logic       pair_valid, cmp_hit, pair_hit;

    genvar gi;
    for (gi = 0; gi < MAX_ENEMY; gi++) begin : g_in_e
        assign in_e[gi] = i_EnemyPosition[POS_W*gi +: POS_W];
    end
    for (gi = 0; gi < MAX_ENEMY_BULLET; gi++) begin : g_in_eb
        assign in_eb[gi] = i_EnemyBulletPosition[POS_W*gi +: POS_W];
    end
    for (gi = 0; gi < MAX_PLAYER_BULLET; gi++) begin : g_in_pb
        assign in_pb[gi] = i_PlayerBulletPosition[POS_W*gi +: POS_W];
    end

    // Steer the current pair (chosen by phase and indices) into the comparator.
    always_comb begin
        cmp_a      = NONE_POS;
        cmp_aw     = '0;
        cmp_ah     = '0;
        cmp_b      = NONE_POS;
        cmp_bw     = '0;
        cmp_bh     = '0;
        pair_valid = 1'b0;
        case (state_q)
            SCAN_PB_E: begin
                cmp_a      = snap_pb_q[a_q];
                cmp_aw     = BUL_W;
                cmp_ah     = BUL_H;
                cmp_b      = snap_e_q[b_q[EW-1:0]];
                cmp_bw     = ENE_W;
                cmp_bh     = ENE_H;
                pair_valid = snap_pbs_q[a_q] & snap_es_q[b_q[EW-1:0]];
            end
`ifdef COLLISION_BULLET_CANCEL_EN
            SCAN_PB_EB: begin
                cmp_a      = snap_pb_q[a_q];
                cmp_aw     = BUL_W;
                cmp_ah     = BUL_H;
                cmp_b      = snap_eb_q[b_q[EBW-1:0]];
                cmp_bw     = BUL_W;
                cmp_bh     = BUL_H;
                pair_valid = snap_pbs_q[a_q] & snap_ebs_q[b_q[EBW-1:0]];
            end
`endif
            SCAN_EB_P: begin
                cmp_a      = snap_eb_q[b_q[EBW-1:0]];
                cmp_aw     = BUL_W;
                cmp_ah     = BUL_H;
                cmp_b      = '{x: snap_px_q, y: PLY_Y};
                cmp_bw     = PLY_W;
                cmp_bh     = PLY_H;
                pair_valid = snap_ebs_q[b_q[EBW-1:0]] & snap_ps_q;
            end
            default: ;
        endcase
    end

    collision_rect_cmp u_cmp (
        .a_pos_i (cmp_a),
        .a_w_i   (cmp_aw),
        .a_h_i   (cmp_ah),
        .b_pos_i (cmp_b),
        .b_w_i   (cmp_bw),
        .b_h_i   (cmp_bh),
        .hit_o   (cmp_hit)
    );

    assign pair_hit = pair_valid & cmp_hit;

    // Scheduler FSM: snapshot, walk the pair phases, accumulate kills, strobe done.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q    <= IDLE;
            for (int k = 0; k < MAX_ENEMY; k++)         snap_e_q[k]  <= NONE_POS;
            for (int k = 0; k < MAX_ENEMY_BULLET; k++)  snap_eb_q[k] <= NONE_POS;
            for (int k = 0; k < MAX_PLAYER_BULLET; k++) snap_pb_q[k] <= NONE_POS;
            snap_px_q  <= '0;
            snap_es_q  <= '0;
            snap_ebs_q <= '0;
            snap_pbs_q <= '0;
            snap_ps_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ek_q       <= '0;
            ebk_q      <= '0;
            pbk_q      <= '0;
            hit_q      <= 1'b0;
            alldown_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (i_FrameStart) begin
                        snap_e_q   <= in_e;
                        snap_eb_q  <= in_eb;
                        snap_pb_q  <= in_pb;
                        snap_px_q  <= i_PlayerPosition;
                        snap_es_q  <= i_EnemyState;
                        snap_ebs_q <= i_EnemyBulletState;
                        snap_pbs_q <= i_PlayerBulletState;
                        snap_ps_q  <= i_PlayerState;
                        ek_q       <= '0;
                        ebk_q      <= '0;
                        pbk_q      <= '0;
                        hit_q      <= 1'b0;
                        alldown_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        a_q        <= '0;
                        b_q        <= '0;
                        state_q    <= SCAN_PB_E;
                    end
                end
                SCAN_PB_E: begin
                    if (pair_hit) begin
                        pbk_q[a_q]         <= 1'b1;
                        ek_q[b_q[EW-1:0]]  <= 1'b1;
                    end
                    if (b_q == E_LAST) begin
                        b_q <= '0;
                        if (a_q == A_LAST) begin
                            a_q     <= '0;
`ifdef COLLISION_BULLET_CANCEL_EN
                            state_q <= SCAN_PB_EB;
`else
                            state_q <= SCAN_EB_P;
`endif
                        end else begin
                            a_q <= a_q + 1'b1;
                        end
                    end else begin
                        b_q <= b_q + 1'b1;
                    end
                end
`ifdef COLLISION_BULLET_CANCEL_EN
                SCAN_PB_EB: begin
                    if (pair_hit) begin
                        pbk_q[a_q]          <= 1'b1;
                        ebk_q[b_q[EBW-1:0]] <= 1'b1;
                    end
                    if (b_q == EB_LAST) begin
                        b_q <= '0;
                        if (a_q == A_LAST) begin
                            a_q     <= '0;
                            state_q <= SCAN_EB_P;
                        end else begin
                            a_q <= a_q + 1'b1;
                        end
                    end else begin
                        b_q <= b_q + 1'b1;
                    end
                end
`endif
                SCAN_EB_P: begin
                    if (pair_hit) begin
                        ebk_q[b_q[EBW-1:0]] <= 1'b1;
                        hit_q               <= 1'b1;
                    end
                    if (b_q == EB_LAST) begin
                        b_q     <= '0;
                        state_q <= DONE;
                    end else begin
                        b_q <= b_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    alldown_q <= &(~snap_es_q | ek_q);
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_EnemyKill        = ek_q;
    assign o_EnemyBulletKill  = ebk_q;
    assign o_PlayerBulletKill = pbk_q;
    assign o_PlayerHit        = hit_q;
    assign o_AllEnemiesDown   = alldown_q;
    assign o_Busy             = busy_q;
    assign o_Done             = done_q;

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Per-frame collision controller for the shooter game core.
- On each frame tick it snapshots all object states and positions, then walks every relevant object pair through one shared rectangle comparator, one pair per clock.
- Replaces the fully parallel comparator array with a time-multiplexed one.
- Produces kill masks and a player-hit flag for the object-update logic, plus a done strobe and an all-enemies-down flag for the game-state FSM.

Parameters:
- MAX_ENEMY, 3, number of enemy slots
- MAX_ENEMY_BULLET, 3, number of enemy bullet slots
- MAX_PLAYER_BULLET, 3, number of player bullet slots
- ENEMY_WIDTH, 36, enemy box width in pixels
- ENEMY_HEIGHT, 24, enemy box height
- PLAYER_WIDTH, 24, player box width
- PLAYER_HEIGHT, 36, player box height
- BULLET_WIDTH, 4, bullet box width (both bullet types)
- BULLET_HEIGHT, 16, bullet box height
- PLAYER_Y, 372, fixed player top-left y coordinate

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous active-low reset
- i_FrameStart  in  1  one-cycle frame tick; starts a scan
- i_EnemyState  in  MAX_ENEMY  alive bits
- i_EnemyBulletState  in  MAX_ENEMY_BULLET  alive bits
- i_PlayerBulletState  in  MAX_PLAYER_BULLET  alive bits
- i_PlayerState  in  1  player alive
- i_EnemyPosition  in  19*MAX_ENEMY  packed {x[9:0], y[8:0]}; slot k at bits [19k+18:19k]
- i_EnemyBulletPosition  in  19*MAX_ENEMY_BULLET  same packing
- i_PlayerBulletPosition  in  19*MAX_PLAYER_BULLET  same packing
- i_PlayerPosition  in  10  player x
- o_EnemyKill  out  MAX_ENEMY  enemies hit this frame
- o_EnemyBulletKill  out  MAX_ENEMY_BULLET  enemy bullets destroyed
- o_PlayerBulletKill  out  MAX_PLAYER_BULLET  player bullets destroyed
- o_PlayerHit  out  1  player hit this frame
- o_AllEnemiesDown  out  1  no enemy alive after applying o_EnemyKill
- o_Busy  out  1  scan in progress
- o_Done  out  1  one-cycle strobe; outputs valid

Behaviour:
- Reset values:
  - Clock and reset are one clock, i_Clk, with reset i_Rst asynchronous and active-low.
  - All outputs are 0 during and after reset, and the FSM is in IDLE.
  - Reset asserted mid-scan aborts the scan immediately and clears the masks; no o_Done is issued.
- FSM states: IDLE, SCAN_PB_E, SCAN_PB_EB, SCAN_EB_P, DONE.
- IDLE:
  - On i_FrameStart, latch all i_* into snapshot registers, clear all kill outputs, set o_Busy, reset the pair indices, and go to SCAN_PB_E.
- SCAN_PB_E:
  - Evaluate (player bullet a, enemy b), a outer and b inner, for MAX_PLAYER_BULLET*MAX_ENEMY cycles.
  - On a hit, set o_PlayerBulletKill[a] and o_EnemyKill[b].
- SCAN_PB_EB:
  - Evaluate (player bullet a, enemy bullet b) over MAX_PLAYER_BULLET*MAX_ENEMY_BULLET cycles.
  - On a hit, set both kill bits.
- SCAN_EB_P:
  - Evaluate (enemy bullet b, player) over MAX_ENEMY_BULLET cycles.
  - On a hit, set o_EnemyBulletKill[b] and o_PlayerHit.
- DONE:
  - o_Done is high for exactly one cycle and o_Busy drops in the same cycle; then go to IDLE.
- Latency:
  - o_Done is high on the cycle after the last pair is evaluated.
  - At defaults with the feature enabled, o_Done is high 22 cycles after the sampling edge of i_FrameStart.
- Output hold: kill outputs, o_PlayerHit and o_AllEnemiesDown hold their values until the next accepted i_FrameStart.
- Pair validity: a pair hits only if both objects' snapshot alive bits are 1; dead pairs still consume one cycle, so latency is fixed.
- Order independence: all pairs use the snapshot alive bits, never in-scan kills. A bullet overlapping two targets kills both, and the result does not depend on scan order.
- Overlap test (strict):
  - Hit when Ax < Bx+Bw and Bx < Ax+Aw and Ay < By+Bh and By < Ay+Ah.
  - Sums are computed at 11 bits (x) and 10 bits (y), so there is no wrap-around.
  - Edges that only touch do not count as a hit.
- Ignored frame ticks: i_FrameStart while o_Busy or in DONE is ignored and is not queued.
- o_AllEnemiesDown: registered at the DONE transition as the AND over k of (~snapEnemyState[k] | o_EnemyKill[k]).

Optional Feature:
- Macro: COLLISION_BULLET_CANCEL_EN
- Defined: the SCAN_PB_EB phase runs, and player and enemy bullets cancel each other.
- Undefined:
  - SCAN_PB_E goes directly to SCAN_EB_P.
  - Bullets pass through each other.
  - Latency at defaults is 13 cycles.

Decomposition:
- Shared package:
  - Object size constants, MAX_* counts, PLAYER_Y.
  - NONE position {720, 500}.
  - The position typedef {x[9:0], y[8:0]}.
  - FSM state encoding.
- Sub-module collision_rect_cmp:
  - Purely combinational.
  - Inputs: two positions and two width/height pairs.
  - Output: one hit bit.
  - One instance, fed by muxes driven by the scheduler's pair indices.

Test Plan:
- Player bullet 0 at (250,150) overlapping enemy 1 at (240,140), others dead, FrameStart -> after 22 cycles o_Done=1, o_EnemyKill=3'b010, o_PlayerBulletKill=3'b001, o_PlayerHit=0.
- Enemy bullet 2 at (210,380), player x=202 alive -> o_PlayerHit=1, o_EnemyBulletKill=3'b100; bullet at x=226 (touching edge) -> no hit.
- Player bullet 1 at (302,260) and enemy bullet 0 at (303,265) -> both kill bits set with the macro defined; with the macro undefined, no kill and o_Done arrives at cycle 13.
- All three enemies alive and all three hit in one frame -> o_AllEnemiesDown=1; same frame with enemy 0 dead in the snapshot and a bullet over it -> o_EnemyKill[0]=0.
- FrameStart pulsed again at cycle 5 of a scan -> ignored, single o_Done at cycle 22; reset asserted at cycle 10 -> outputs 0, IDLE, no o_Done.
